dekatron_counter_arbiter: RTL and testbench
===========================================

DEKATRON_COUNTER_ARBITER -- requirements
Module: dekatron_counter_arbiter

Interface
REQ-001 Parameter D_NUM, default 3: number of dekatron digits; data width W = D_NUM*4 (BCD, digit 0 in [3:0]).
REQ-002 Parameter TIMEOUT, default 4000: max Clk cycles allowed for one counter operation.
REQ-003 Port Clk  in  1  single system clock; all state on rising edge.
REQ-004 Port Rst  in  1  asynchronous, active-high reset.
REQ-005 Ports a_req / b_req  in  1  level request from requester A / B, held until matching ack.
REQ-006 Ports a_op / b_op  in  2  operation: 00 inc, 01 dec, 10 set, 11 set-zero.
REQ-007 Ports a_data / b_data  in  W  load value, used only for op 10.
REQ-008 Ports a_ack / b_ack  out  1  one-cycle completion pulse to A / B.
REQ-009 Port res  out  W  counter value captured at completion of last operation.
REQ-010 Port busy  out  1  high whenever FSM is not IDLE.
REQ-011 Port err  out  1  sticky timeout flag.
REQ-012 Port cnt_request  out  1  one-cycle start pulse to the shared DekatronCounter.
REQ-013 Ports cnt_dec, cnt_set, cnt_setzero  out  1 each  counter mode controls.
REQ-014 Port cnt_in  out  W  load value to counter.
REQ-015 Port cnt_ready  in  1  counter idle/done indication.
REQ-016 Port cnt_out  in  W  counter current value.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK.
REQ-018 IDLE -> ISSUE when cnt_ready=1 and a_req|b_req; otherwise stay IDLE (no grant while cnt_ready=0).
REQ-019 Arbitration round-robin: single requester wins; both requesting -> the one not granted last; last-grant register resets to B so A wins first tie.
REQ-020 On grant, op, data and grant owner SHALL be latched; later changes on a_*/b_* SHALL not affect the operation in flight.
REQ-021 cnt_dec=(op==01), cnt_set=(op==10), cnt_setzero=(op==11), cnt_in=data if op==10 else 0; driven from latched values, stable ISSUE through WAIT_DONE, all 0 in IDLE and ACK.
REQ-022 ISSUE: cnt_request=1 for exactly one cycle, then -> WAIT_BUSY.
REQ-023 WAIT_BUSY: stay until cnt_ready=0, then -> WAIT_DONE.
REQ-024 WAIT_DONE: stay until cnt_ready=1; then res <= cnt_out and -> ACK.
REQ-025 ACK: owner's ack=1 for one cycle, other ack 0, -> IDLE; minimum grant-to-ack latency 4 cycles.
REQ-026 A request deasserted after grant SHALL still complete and ack; a request deasserted before grant is never served.
REQ-027 Timeout counter clears on grant, increments in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT: err <= 1, res unchanged, -> ACK (owner still acked).
REQ-028 err SHALL clear only on Rst.
REQ-029 At most one cnt_request per grant; never two acks in one cycle; requester re-asserting req in ACK cycle is eligible in the following IDLE.

Reset
REQ-030 Rst=1 SHALL asynchronously force IDLE, res=0, err=0, a_ack=b_ack=0, cnt_request=0, all cnt_* controls 0, busy=0, last-grant=B, timeout counter 0.
REQ-031 Rst mid-operation SHALL abandon the operation without ack; after release arbitration restarts from IDLE.

Verification
REQ-032 Counter at 000, A issues inc 5 times -> five a_ack pulses, res=001..005, exactly five cnt_request pulses, b_ack never 1.
REQ-033 A and B both hold inc from IDLE -> grants alternate A,B,A,B; after 4 acks res=4 (starting 000).
REQ-034 B set 10 data=12'h255, then A dec -> res=255 then 254; cnt_in=0 during A's dec.
REQ-035 Counter model holds cnt_ready=1 forever after request -> after TIMEOUT cycles err=1, owner acked, res unchanged, next request still served.
REQ-036 Rst asserted in WAIT_DONE -> no ack, busy=0, cnt_request=0 immediately; after release A inc from 000 gives res=001.
REQ-037 A pulses req for one cycle while B in flight, then drops -> A never acked; cnt_request count equals ack count.

Source files
------------

// File: rtl/dekatron_counter_arbiter_if.sv
// rtl/dekatron_counter_arbiter_if.sv - requester, result and counter-side signals of the dekatron arbiter
// slave : arbiter side (takes requests and counter status, drives acks, result and counter controls)
// master: environment side (requesters A/B plus the shared DekatronCounter)
interface dekatron_counter_arbiter_if #(
    parameter int D_NUM = 3
);
    localparam int W = D_NUM * 4;

    logic         a_req;
    logic [1:0]   a_op;
    logic [W-1:0] a_data;
    logic         a_ack;
    logic         b_req;
    logic [1:0]   b_op;
    logic [W-1:0] b_data;
    logic         b_ack;
    logic [W-1:0] res;
    logic         busy;
    logic         err;
    logic         cnt_request;
    logic         cnt_dec;
    logic         cnt_set;
    logic         cnt_setzero;
    logic [W-1:0] cnt_in;
    logic         cnt_ready;
    logic [W-1:0] cnt_out;

    modport slave (
        input  a_req, a_op, a_data, b_req, b_op, b_data, cnt_ready, cnt_out,
        output a_ack, b_ack, res, busy, err,
        output cnt_request, cnt_dec, cnt_set, cnt_setzero, cnt_in
    );

    modport master (
        output a_req, a_op, a_data, b_req, b_op, b_data, cnt_ready, cnt_out,
        input  a_ack, b_ack, res, busy, err,
        input  cnt_request, cnt_dec, cnt_set, cnt_setzero, cnt_in
    );
endinterface

// File: rtl/dekatron_counter_arbiter.sv
// rtl/dekatron_counter_arbiter.sv - round-robin arbiter sharing one dekatron counter between requesters A and B
// Clk : system clock, all state on rising edge
// Rst : asynchronous active-high reset
// bus : slave side of dekatron_counter_arbiter_if (a_*/b_* requests and acks, res/busy/err, cnt_* counter link)
module dekatron_counter_arbiter #(
    parameter int D_NUM   = 3,
    parameter int TIMEOUT = 4000
) (
    input  logic                          Clk,
    input  logic                          Rst,
    dekatron_counter_arbiter_if.slave     bus
);
    localparam int W  = D_NUM * 4;
    // Two spare codes: the counter can run one past TIMEOUT when a WAIT_BUSY exit
    // coincides with the limit, and the compare must not wrap.
    localparam int TW = $clog2(TIMEOUT + 2) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic          last_b_q, last_b_d;     // 1 = B was granted last
    logic          owner_b_q, owner_b_d;   // 1 = operation in flight belongs to B
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  res_q, res_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          grant_b;
    logic [TW-1:0] tmo_inc;
    logic          tmo_hit;
    logic          in_op;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            owner_b_q <= 1'b0;
            op_q      <= 2'b00;
            data_q    <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            owner_b_q <= owner_b_d;
            op_q      <= op_d;
            data_q    <= data_d;
            res_q     <= res_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign tmo_inc = tmo_q + 1'b1;
    assign tmo_hit = (tmo_inc >= TW'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        owner_b_d = owner_b_q;
        op_d      = op_q;
        data_d    = data_q;
        res_d     = res_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        // B wins only when A is absent or when A held the last grant.
        grant_b   = bus.b_req && (!bus.a_req || !last_b_q);

        case (state_q)
            IDLE: begin
                if (bus.cnt_ready && (bus.a_req || bus.b_req)) begin
                    owner_b_d = grant_b;
                    last_b_d  = grant_b;
                    op_d      = grant_b ? bus.b_op : bus.a_op;
                    data_d    = grant_b ? bus.b_data : bus.a_data;
                    tmo_d     = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tmo_d = tmo_inc;
                if (!bus.cnt_ready) begin
                    state_d = WAIT_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            WAIT_DONE: begin
                tmo_d = tmo_inc;
                if (bus.cnt_ready) begin
                    res_d   = bus.cnt_out;
                    state_d = ACK;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter controls come from the latched request so they stay stable for the
    // whole operation and read as zero outside it.
    assign in_op           = (state_q == ISSUE) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign bus.cnt_request = (state_q == ISSUE);
    assign bus.cnt_dec     = in_op && (op_q == 2'b01);
    assign bus.cnt_set     = in_op && (op_q == 2'b10);
    assign bus.cnt_setzero = in_op && (op_q == 2'b11);
    assign bus.cnt_in      = (in_op && (op_q == 2'b10)) ? data_q : '0;

    assign bus.a_ack = (state_q == ACK) && !owner_b_q;
    assign bus.b_ack = (state_q == ACK) && owner_b_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.res   = res_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_dekatron_counter_arbiter.sv
// tb/tb_dekatron_counter_arbiter.sv - directed self-checking bench for dekatron_counter_arbiter
module tb_dekatron_counter_arbiter;
    localparam int D_NUM   = 3;
    localparam int W       = D_NUM * 4;
    localparam int TIMEOUT = 20;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    int   n_req;
    int   n_aack;
    int   n_back;
    bit   both_ack;
    bit   stuck;
    int   cd;
    logic [W-1:0] pend;

    dekatron_counter_arbiter_if #(.D_NUM(D_NUM)) bus ();

    dekatron_counter_arbiter #(.D_NUM(D_NUM), .TIMEOUT(TIMEOUT)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input bit down);
        logic [W-1:0] r;
        logic [3:0]   d;
        bit           carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < D_NUM; i++) begin
            if (carry) begin
                d = r[i*4 +: 4];
                if (!down) begin
                    if (d == 4'd9) d = 4'd0;
                    else begin d = d + 4'd1; carry = 1'b0; end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin d = d - 4'd1; carry = 1'b0; end
                end
                r[i*4 +: 4] = d;
            end
        end
        return r;
    endfunction

    // Shared counter model: goes not-ready on a request, finishes three cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cnt_ready <= 1'b1;
            bus.cnt_out   <= '0;
            cd            <= 0;
            pend          <= '0;
        end else if (cd > 0) begin
            if (cd == 1) begin
                bus.cnt_out   <= pend;
                bus.cnt_ready <= 1'b1;
            end
            cd <= cd - 1;
        end else if (bus.cnt_request && !stuck) begin
            bus.cnt_ready <= 1'b0;
            cd            <= 3;
            if (bus.cnt_setzero)  pend <= '0;
            else if (bus.cnt_set) pend <= bus.cnt_in;
            else                  pend <= bcd_step(bus.cnt_out, bus.cnt_dec);
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.cnt_request)          n_req    <= n_req + 1;
            if (bus.a_ack)                n_aack   <= n_aack + 1;
            if (bus.b_ack)                n_back   <= n_back + 1;
            if (bus.a_ack && bus.b_ack)   both_ack <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output bit got_a, output bit got_b);
        got_a = 1'b0;
        got_b = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) begin
                got_a = bus.a_ack;
                got_b = bus.b_ack;
                return;
            end
        end
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cnt_request) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic op_a(input logic [1:0] op, input logic [W-1:0] data, output bit got_a, output bit got_b);
        bus.a_op   = op;
        bus.a_data = data;
        bus.a_req  = 1'b1;
        wait_ack(got_a, got_b);
        bus.a_req  = 1'b0;
    endtask

    task automatic op_b(input logic [1:0] op, input logic [W-1:0] data, output bit got_a, output bit got_b);
        bus.b_op   = op;
        bus.b_data = data;
        bus.b_req  = 1'b1;
        wait_ack(got_a, got_b);
        bus.b_req  = 1'b0;
    endtask

    initial begin
        bit ga, gb, seen;
        int snap_a, snap_b, snap_r;
        logic [W-1:0] exp_res [4];
        exp_res[0] = 12'h001; exp_res[1] = 12'h002; exp_res[2] = 12'h003; exp_res[3] = 12'h004;

        tests = 0; fails = 0;
        n_req = 0; n_aack = 0; n_back = 0; both_ack = 1'b0; stuck = 1'b0;
        bus.a_req = 1'b0; bus.a_op = 2'b00; bus.a_data = '0;
        bus.b_req = 1'b0; bus.b_op = 2'b00; bus.b_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_res", 32'(bus.res), 32'd0);
        check("rst_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
        check("rst_cnt_ctl", {27'd0, bus.cnt_request, bus.cnt_dec, bus.cnt_set, bus.cnt_setzero, |bus.cnt_in}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // A increments five times from 000
        for (int k = 0; k < 5; k++) begin
            op_a(2'b00, '0, ga, gb);
            check("inc5_a_ack", {30'd0, ga, gb}, 32'd2);
            check("inc5_res", 32'(bus.res), 32'(k + 1));
        end
        check("inc5_req_count", 32'(n_req), 32'd5);
        check("inc5_b_ack_count", 32'(n_back), 32'd0);

        // Both hold inc from IDLE after reset: A, B, A, B
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.a_op = 2'b00; bus.b_op = 2'b00;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(ga, gb);
            check("rr_owner", {30'd0, ga, gb}, (k % 2 == 0) ? 32'd2 : 32'd1);
            check("rr_res", 32'(bus.res), 32'(exp_res[k]));
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        @(negedge clk);

        // B loads 255, then A decrements
        bus.b_op = 2'b10; bus.b_data = 12'h255; bus.b_req = 1'b1;
        wait_req(seen);
        check("set_req_seen", 32'(seen), 32'd1);
        check("set_ctl", {29'd0, bus.cnt_dec, bus.cnt_set, bus.cnt_setzero}, 32'd2);
        check("set_cnt_in", 32'(bus.cnt_in), 32'h255);
        bus.b_data = 12'h999;
        wait_ack(ga, gb);
        bus.b_req = 1'b0;
        check("set_b_ack", {30'd0, ga, gb}, 32'd1);
        check("set_res", 32'(bus.res), 32'h255);

        bus.a_op = 2'b01; bus.a_data = 12'h777; bus.a_req = 1'b1;
        wait_req(seen);
        check("dec_req_seen", 32'(seen), 32'd1);
        check("dec_ctl", {29'd0, bus.cnt_dec, bus.cnt_set, bus.cnt_setzero}, 32'd4);
        check("dec_cnt_in", 32'(bus.cnt_in), 32'd0);
        wait_ack(ga, gb);
        bus.a_req = 1'b0;
        check("dec_a_ack", {30'd0, ga, gb}, 32'd2);
        check("dec_res", 32'(bus.res), 32'h254);

        // Reset while waiting for the counter to finish
        bus.a_op = 2'b00; bus.a_req = 1'b1;
        wait_req(seen);
        check("rstmid_req_seen", 32'(seen), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_busy_before", 32'(bus.busy), 32'd1);
        snap_a = n_aack;
        rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_outs", {26'd0, bus.cnt_request, bus.cnt_dec, bus.cnt_set, bus.cnt_setzero, bus.a_ack, bus.b_ack}, 32'd0);
        check("rstmid_res", 32'(bus.res), 32'd0);
        bus.a_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid_no_ack", 32'(n_aack), 32'(snap_a));
        op_a(2'b00, '0, ga, gb);
        check("rstmid_after_ack", {30'd0, ga, gb}, 32'd2);
        check("rstmid_after_res", 32'(bus.res), 32'h001);

        // Counter never goes busy: timeout, owner still acked
        stuck = 1'b1;
        op_a(2'b00, '0, ga, gb);
        check("tmo_a_ack", {30'd0, ga, gb}, 32'd2);
        check("tmo_err", 32'(bus.err), 32'd1);
        check("tmo_res", 32'(bus.res), 32'h001);
        stuck = 1'b0;
        @(negedge clk);
        op_b(2'b00, '0, ga, gb);
        check("tmo_next_b_ack", {30'd0, ga, gb}, 32'd1);
        check("tmo_next_res", 32'(bus.res), 32'h002);
        check("tmo_err_sticky", 32'(bus.err), 32'd1);

        // A pulses req for one cycle while B is in flight
        @(negedge clk);
        snap_a = n_aack; snap_b = n_back; snap_r = n_req;
        bus.b_op = 2'b00; bus.b_req = 1'b1;
        wait_req(seen);
        check("pulse_req_seen", 32'(seen), 32'd1);
        bus.a_op = 2'b00; bus.a_req = 1'b1;
        @(negedge clk);
        bus.a_req = 1'b0;
        wait_ack(ga, gb);
        bus.b_req = 1'b0;
        check("pulse_b_ack", {30'd0, ga, gb}, 32'd1);
        check("pulse_res", 32'(bus.res), 32'h003);
        repeat (20) @(negedge clk);
        check("pulse_a_never", 32'(n_aack - snap_a), 32'd0);
        check("pulse_req_eq_ack", 32'(n_req - snap_r), 32'(n_back - snap_b + n_aack - snap_a));
        check("pulse_idle", 32'(bus.busy), 32'd0);
        check("never_two_acks", 32'(both_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
